// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// supported opcodes, datapath select encodings and the DECODE dispatch helper.
package mips_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // State following DECODE; FETCH means the opcode is unsupported.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_RTYPE:     return S_R_EXEC;
      OP_ADDI:      return S_ADDI_EXEC;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      default:      return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle MIPS control unit (Moore FSM).
// Params : MEM_WAIT  extra wait cycles per memory access (0..15)
// Inputs : Clk, Reset (sync, active high), Op (IR[31:26], sampled in DECODE)
// Outputs: PC enables/select, memory and register-file controls, ALU selects,
//          IllegalOp (one cycle, in the FETCH after an unsupported opcode),
//          State (current state encoding for debug)
module control_unit
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  output logic       PCwrite,
  output logic       PCwriteCOND,
  output logic [1:0] PCsource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRwrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [3:0] MW = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [5:0] opcode_q;
  logic       illegal_q;
  logic       wait_done;
  logic       counting;

  assign wait_done = (cnt_q == MW);
  assign counting  = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (counting && !wait_done)
        cnt_q <= cnt_q + 4'd1;
      if (state_q == S_DECODE)
        opcode_q <= Op;
      illegal_q <= (state_q == S_DECODE) && (decode_target(Op) == S_FETCH);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:      state_d = S_FETCH;
      S_FETCH:     if (wait_done) state_d = S_DECODE;
      S_DECODE:    state_d = decode_target(Op);
      // Load/store split uses the opcode latched in DECODE, not the live Op.
      S_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (wait_done) state_d = S_MEM_WB;
      S_MEM_WRITE: if (wait_done) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                   state_d = S_FETCH;
      default:     state_d = S_INIT;
    endcase
  end

  always_comb begin
    PCwrite     = 1'b0;
    PCwriteCOND = 1'b0;
    PCsource    = PCS_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRwrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ASB_B;
    ALUOp       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (wait_done) begin
          IRwrite = 1'b1;
          ALUSrcB = ASB_FOUR;
          PCwrite = 1'b1;
        end
      end
      S_DECODE:    ALUSrcB = ASB_IMM_SH2;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ASB_IMM;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDI_WB:   RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCwriteCOND = 1'b1;
        PCsource    = PCS_ALUOUT;
      end
      S_JUMP: begin
        PCwrite  = 1'b1;
        PCsource = PCS_JUMP;
      end
      default: ;
    endcase
  end

  assign IllegalOp = illegal_q;
  assign State     = state_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc;
    logic [1:0] pcs;
    logic       iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop;
    logic       ill;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] op [3];

  logic [3:0] st_o [3];
  logic       pcw_o [3], pcwc_o [3], iord_o [3], mr_o [3], mw_o [3], irw_o [3];
  logic       m2r_o [3], rdst_o [3], rw_o [3], asa_o [3], ill_o [3];
  logic [1:0] pcs_o [3], asb_o [3], aop_o [3];
  exp_t       act [3];

  always #5 Clk = ~Clk;

  control_unit #(.MEM_WAIT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Op(op[0]),
    .PCwrite(pcw_o[0]), .PCwriteCOND(pcwc_o[0]), .PCsource(pcs_o[0]),
    .IorD(iord_o[0]), .MemRead(mr_o[0]), .MemWrite(mw_o[0]), .IRwrite(irw_o[0]),
    .MemtoReg(m2r_o[0]), .RegDst(rdst_o[0]), .RegWrite(rw_o[0]), .ALUSrcA(asa_o[0]),
    .ALUSrcB(asb_o[0]), .ALUOp(aop_o[0]), .IllegalOp(ill_o[0]), .State(st_o[0]));

  control_unit #(.MEM_WAIT(2)) dut1 (
    .Clk(Clk), .Reset(Reset), .Op(op[1]),
    .PCwrite(pcw_o[1]), .PCwriteCOND(pcwc_o[1]), .PCsource(pcs_o[1]),
    .IorD(iord_o[1]), .MemRead(mr_o[1]), .MemWrite(mw_o[1]), .IRwrite(irw_o[1]),
    .MemtoReg(m2r_o[1]), .RegDst(rdst_o[1]), .RegWrite(rw_o[1]), .ALUSrcA(asa_o[1]),
    .ALUSrcB(asb_o[1]), .ALUOp(aop_o[1]), .IllegalOp(ill_o[1]), .State(st_o[1]));

  control_unit #(.MEM_WAIT(3)) dut2 (
    .Clk(Clk), .Reset(Reset), .Op(op[2]),
    .PCwrite(pcw_o[2]), .PCwriteCOND(pcwc_o[2]), .PCsource(pcs_o[2]),
    .IorD(iord_o[2]), .MemRead(mr_o[2]), .MemWrite(mw_o[2]), .IRwrite(irw_o[2]),
    .MemtoReg(m2r_o[2]), .RegDst(rdst_o[2]), .RegWrite(rw_o[2]), .ALUSrcA(asa_o[2]),
    .ALUSrcB(asb_o[2]), .ALUOp(aop_o[2]), .IllegalOp(ill_o[2]), .State(st_o[2]));

  for (genvar g = 0; g < 3; g++) begin : g_act
    assign act[g] = {st_o[g], pcw_o[g], pcwc_o[g], pcs_o[g], iord_o[g], mr_o[g],
                     mw_o[g], irw_o[g], m2r_o[g], rdst_o[g], rw_o[g], asa_o[g],
                     asb_o[g], aop_o[g], ill_o[g]};
  end

  // Reference model: each instance owns a queue of the per-cycle output
  // records still to come for the current instruction.
  int   mwv [3] = '{0, 2, 3};
  exp_t q [3][$];
  exp_t cur [3];
  bit   valid = 1'b0;
  int   total = 0;
  int   bad = 0;

  function automatic exp_t rec(input state_t s);
    exp_t r = '0;
    r.st = s;
    return r;
  endfunction

  function automatic void push_fetch(input int k, input logic ill);
    exp_t r;
    for (int i = 0; i <= mwv[k]; i++) begin
      r = rec(S_FETCH);
      r.mr = 1'b1;
      if (i == 0) r.ill = ill;
      if (i == mwv[k]) begin
        r.irw = 1'b1; r.asb = 2'b01; r.pcw = 1'b1;
      end
      q[k].push_back(r);
    end
    r = rec(S_DECODE);
    r.asb = 2'b11;
    q[k].push_back(r);
  endfunction

  function automatic void push_body(input int k, input logic [5:0] o);
    exp_t r;
    case (o)
      6'h23, 6'h2B: begin
        r = rec(S_MEM_ADDR); r.asa = 1'b1; r.asb = 2'b10; q[k].push_back(r);
        for (int i = 0; i <= mwv[k]; i++) begin
          r = (o == 6'h23) ? rec(S_MEM_READ) : rec(S_MEM_WRITE);
          r.iord = 1'b1;
          if (o == 6'h23) r.mr = 1'b1; else r.mw = 1'b1;
          q[k].push_back(r);
        end
        if (o == 6'h23) begin
          r = rec(S_MEM_WB); r.rw = 1'b1; r.m2r = 1'b1; q[k].push_back(r);
        end
      end
      6'h00: begin
        r = rec(S_R_EXEC); r.asa = 1'b1; r.aop = 2'b10; q[k].push_back(r);
        r = rec(S_R_WB); r.rw = 1'b1; r.rdst = 1'b1; q[k].push_back(r);
      end
      6'h08: begin
        r = rec(S_ADDI_EXEC); r.asa = 1'b1; r.asb = 2'b10; q[k].push_back(r);
        r = rec(S_ADDI_WB); r.rw = 1'b1; q[k].push_back(r);
      end
      6'h04: begin
        r = rec(S_BRANCH); r.asa = 1'b1; r.aop = 2'b01; r.pcwc = 1'b1; r.pcs = 2'b01;
        q[k].push_back(r);
      end
      6'h02: begin
        r = rec(S_JUMP); r.pcw = 1'b1; r.pcs = 2'b10; q[k].push_back(r);
      end
      default: push_fetch(k, 1'b1);
    endcase
  endfunction

  always @(posedge Clk) begin
    for (int k = 0; k < 3; k++) begin
      if (Reset) begin
        q[k].delete();
        cur[k] = rec(S_INIT);
      end else begin
        if (cur[k].st == 4'(S_DECODE)) push_body(k, op[k]);
        if (q[k].size() == 0) push_fetch(k, 1'b0);
        cur[k] = q[k].pop_front();
      end
    end
    if (Reset) valid = 1'b1;
  end

  task automatic step();
    @(negedge Clk);
    if (valid) begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (act[k] !== cur[k]) begin
          bad++;
          $display("FAIL model inst%0d t=%0t: got %h expected %h", k, $time, act[k], cur[k]);
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  function automatic logic [5:0] rand_op();
    int unsigned r = $urandom_range(0, 9);
    case (r)
      0: return 6'h00;
      1: return 6'h23;
      2: return 6'h2B;
      3: return 6'h08;
      4: return 6'h04;
      5: return 6'h02;
      6, 7: return 6'($urandom_range(0, 63));
      default: return 6'h23;
    endcase
  endfunction

  exp_t tr [3][12];
  int   lit0 [6];
  int   lit1 [11];
  int   lit2 [12];

  initial begin
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) op[k] = 6'h00;

    // Phase 1: R-type (MW0), lw (MW2), sw with Op switched to lw after DECODE (MW3).
    step(); step();
    Reset = 1'b0;
    op[0] = 6'h00; op[1] = 6'h23; op[2] = 6'h2B;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      for (int k = 0; k < 3; k++) tr[k][i] = act[k];
      if (i == 6) op[2] = 6'h23;
    end
    lit0 = '{0, 1, 2, 7, 8, 1};
    lit1 = '{0, 1, 1, 1, 2, 3, 4, 4, 4, 5, 1};
    lit2 = '{0, 1, 1, 1, 1, 2, 3, 6, 6, 6, 6, 1};
    for (int i = 0; i < 6; i++)  chk("r_state_seq", int'(tr[0][i].st), lit0[i]);
    for (int i = 0; i < 11; i++) chk("lw_state_seq", int'(tr[1][i].st), lit1[i]);
    for (int i = 0; i < 12; i++) chk("sw_state_seq", int'(tr[2][i].st), lit2[i]);
    chk("r_fetch_pcw", int'(tr[0][1].pcw), 1);
    chk("r_fetch_irw", int'(tr[0][1].irw), 1);
    chk("r_exec_aluop", int'(tr[0][3].aop), 2);
    chk("r_wb_rdst", int'(tr[0][4].rdst), 1);
    chk("lw_fetch1_irw", int'(tr[1][1].irw), 0);
    chk("lw_fetch3_irw", int'(tr[1][3].irw), 1);
    chk("lw_read_iord", int'(tr[1][7].iord), 1);
    chk("lw_wb_m2r", int'(tr[1][9].m2r), 1);
    chk("sw_write_mw", int'(tr[2][8].mw), 1);
    chk("sw_write_mr", int'(tr[2][8].mr), 0);

    // Phase 2: illegal (MW0), beq (MW2), reset during 2nd MEM_READ (MW3).
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    op[0] = 6'h3F; op[1] = 6'h04; op[2] = 6'h23;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      for (int k = 0; k < 3; k++) tr[k][i] = act[k];
      Reset = (i == 8);
    end
    chk("ill_fetch_state", int'(tr[0][3].st), 1);
    chk("ill_flag_set", int'(tr[0][3].ill), 1);
    chk("ill_flag_cleared", int'(tr[0][4].ill), 0);
    for (int i = 0; i < 9; i++) chk("ill_no_write", int'(tr[0][i].rw | tr[0][i].mw), 0);
    chk("beq_state", int'(tr[1][5].st), 11);
    chk("beq_pcwc", int'(tr[1][5].pcwc), 1);
    chk("beq_pcs", int'(tr[1][5].pcs), 1);
    chk("beq_aluop", int'(tr[1][5].aop), 1);
    chk("beq_pcw", int'(tr[1][5].pcw), 0);
    chk("beq_next_fetch", int'(tr[1][6].st), 1);
    chk("rst_mid_read_pre", int'(tr[2][8].st), 4);
    chk("rst_mid_read_init", int'(tr[2][9]), 0);
    chk("rst_mid_read_fetch", int'(tr[2][10].st), 1);

    // Phase 3: random opcodes and occasional reset against the model.
    repeat (3000) begin
      step();
      Reset = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 3; k++) op[k] = rand_op();
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
